// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 32-bit ALU between two requesters, each with a one-entry response register.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 wins ties; RR_INIT ignored).
module alu_arbiter #(
  parameter logic RR_INIT = 1'b1,
  parameter int   DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [2:0]        r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_result,
  output logic              r0_zero,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [2:0]        r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_result,
  output logic              r1_zero
);

  localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

  // Shift amount is the whole B operand, so any B at or beyond the width clears the result.
  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      3'b000: res = a + b;
      3'b001: res = a - b;
      3'b010: res = a | b;
      3'b011: res = a & b;
      3'b100: res = (b >= SH_LIM) ? '0 : (a << b);
      3'b101: res = (b >= SH_LIM) ? '0 : (a >> b);
      3'b110: res = a ^ b;
      default: res = (a < b) ? DATA_W'(1) : '0;
    endcase
    return res;
  endfunction

  logic              w_e0_p0;
  logic              w_e1_p0;
  logic              w_gnt0_p0;
  logic              w_gnt1_p0;
  logic [2:0]        w_op_p0;
  logic [DATA_W-1:0] w_a_p0;
  logic [DATA_W-1:0] w_b_p0;
  logic [DATA_W-1:0] w_res_p0;
  logic              w_zero_p0;

  logic              r_vld0_p1;
  logic              r_vld1_p1;
  logic [DATA_W-1:0] r_res0_p1;
  logic [DATA_W-1:0] r_res1_p1;
  logic              r_zero0_p1;
  logic              r_zero1_p1;

  // ---- p0: eligibility, grant, operand mux, shared ALU ----
  assign w_e0_p0 = r0_valid && (!r_vld0_p1 || r0_rsp_ready);
  assign w_e1_p0 = r1_valid && (!r_vld1_p1 || r1_rsp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_gnt0_p0 = w_e0_p0;
  assign w_gnt1_p0 = w_e1_p0 && !w_e0_p0;
`else
  // r_last holds the most recently granted port; the other one wins a tie.
  logic r_last;

  assign w_gnt0_p0 = w_e0_p0 && (!w_e1_p0 || r_last);
  assign w_gnt1_p0 = w_e1_p0 && (!w_e0_p0 || !r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= RR_INIT;
    end else if (w_gnt0_p0 || w_gnt1_p0) begin
      r_last <= w_gnt1_p0;
    end
  end
`endif

  assign r0_ready = w_gnt0_p0;
  assign r1_ready = w_gnt1_p0;

  assign w_op_p0   = w_gnt1_p0 ? r1_op : r0_op;
  assign w_a_p0    = w_gnt1_p0 ? r1_a  : r0_a;
  assign w_b_p0    = w_gnt1_p0 ? r1_b  : r0_b;
  assign w_res_p0  = alu_f(w_op_p0, w_a_p0, w_b_p0);
  assign w_zero_p0 = (w_res_p0 == '0);

  // ---- p1: per-port response registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld0_p1  <= 1'b0;
      r_res0_p1  <= '0;
      r_zero0_p1 <= 1'b0;
    end else if (w_gnt0_p0) begin
      r_vld0_p1  <= 1'b1;
      r_res0_p1  <= w_res_p0;
      r_zero0_p1 <= w_zero_p0;
    end else if (r0_rsp_ready) begin
      r_vld0_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1_p1  <= 1'b0;
      r_res1_p1  <= '0;
      r_zero1_p1 <= 1'b0;
    end else if (w_gnt1_p0) begin
      r_vld1_p1  <= 1'b1;
      r_res1_p1  <= w_res_p0;
      r_zero1_p1 <= w_zero_p0;
    end else if (r1_rsp_ready) begin
      r_vld1_p1  <= 1'b0;
    end
  end

  assign r0_rsp_valid = r_vld0_p1;
  assign r0_result    = r_res0_p1;
  assign r0_zero      = r_zero0_p1;
  assign r1_rsp_valid = r_vld1_p1;
  assign r1_result    = r_res1_p1;
  assign r1_zero      = r_zero1_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the driver predicts grants and results, and a monitor checks each response handshake.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLL = 3'd4, OP_SRL = 3'd5,
                         OP_XOR = 3'd6, OP_SLT = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_zero;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_zero;
  logic [2:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b, r0_result, r1_result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        m_vld0, m_vld1;
  int          m_last;

  alu_arbiter #(.RR_INIT(1'b1), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result), .r0_zero(r0_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result), .r1_zero(r1_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub;
    ua = a;
    ub = b;
    case (op)
      3'd0: return 32'((ua + ub) % 64'h1_0000_0000);
      3'd1: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return (ub >= 32) ? 32'd0 : 32'((ua * (64'd1 << ub)) % 64'h1_0000_0000);
      3'd5: return (ub >= 32) ? 32'd0 : 32'(ua / (64'd1 << ub));
      3'd6: return a ^ b;
      default: return (ua < ub) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd31;
      3: return 32'd32;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_vld0 = 1'b0;
    m_vld1 = 1'b0;
    m_last = 1;
  endtask

  // One clock of stimulus; predicts the grant from the model's view of the response slots.
  task automatic cycle(input logic v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic rr0,
                       input logic v1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr1, output int g);
    bit e0, e1;
    int exp_g;
    logic [31:0] res;
    @(negedge clk);
    r0_valid = v0; r0_op = o0; r0_a = a0; r0_b = b0; r0_rsp_ready = rr0;
    r1_valid = v1; r1_op = o1; r1_a = a1; r1_b = b1; r1_rsp_ready = rr1;
    #1;
    e0 = v0 && (!m_vld0 || rr0);
    e1 = v1 && (!m_vld1 || rr1);
    if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = (m_last == 0) ? 1 : 0;
`endif
    end else if (e0) exp_g = 0;
    else if (e1) exp_g = 1;
    else exp_g = -1;
    chk("rsp_valid0", 32'(r0_rsp_valid), 32'(m_vld0));
    chk("rsp_valid1", 32'(r1_rsp_valid), 32'(m_vld1));
    chk("ready0", 32'(r0_ready), 32'(exp_g == 0));
    chk("ready1", 32'(r1_ready), 32'(exp_g == 1));
    if (exp_g == 0) begin
      res = ref_alu(o0, a0, b0);
      q0.push_back({res == 32'd0, res});
      m_last = 0;
    end else if (exp_g == 1) begin
      res = ref_alu(o1, a1, b1);
      q1.push_back({res == 32'd0, res});
      m_last = 1;
    end
    if (exp_g == 0) m_vld0 = 1'b1; else if (rr0) m_vld0 = 1'b0;
    if (exp_g == 1) m_vld1 = 1'b1; else if (rr1) m_vld1 = 1'b0;
    g = r1_ready ? 1 : (r0_ready ? 0 : -1);
  endtask

  task automatic idle(input logic rr0, input logic rr1);
    int g;
    cycle(1'b0, 3'd0, 32'd0, 32'd0, rr0, 1'b0, 3'd0, 32'd0, 32'd0, rr1, g);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero);
    int g;
    cycle(1'b1, op, a, b, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, g);
    chk({nm, "_gnt"}, 32'(g), 32'd0);
    idle(1'b1, 1'b1);
    chk({nm, "_result"}, r0_result, exp_res);
    chk({nm, "_zero"}, 32'(r0_zero), 32'(exp_zero));
  endtask

  // Response monitor: consumes a result whenever a port's response handshake is about to complete.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1) begin
        if (r0_rsp_valid && r0_rsp_ready) begin
          if (q0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp0_unexpected: got %h expected no response", r0_result);
          end else begin
            e = q0.pop_front();
            chk("rsp0_result", r0_result, e[31:0]);
            chk("rsp0_zero", 32'(r0_zero), 32'(e[32]));
          end
        end
        if (r1_rsp_valid && r1_rsp_ready) begin
          if (q1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp1_unexpected: got %h expected no response", r1_result);
          end else begin
            e = q1.pop_front();
            chk("rsp1_result", r1_result, e[31:0]);
            chk("rsp1_zero", 32'(r1_zero), 32'(e[32]));
          end
        end
      end
    end
  end

  initial begin
    int g;
    int exp_g;
    logic        pv[2];
    logic [2:0]  pop[2];
    logic [31:0] pa[2], pb[2];
    logic        rr[2];

    rst_n = 1'b1;
    r0_valid = 1'b0; r0_op = 3'd0; r0_a = 32'd0; r0_b = 32'd0; r0_rsp_ready = 1'b0;
    r1_valid = 1'b0; r1_op = 3'd0; r1_a = 32'd0; r1_b = 32'd0; r1_rsp_ready = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid0", 32'(r0_rsp_valid), 32'd0);
    chk("rst_rsp_valid1", 32'(r1_rsp_valid), 32'd0);
    chk("rst_result0", r0_result, 32'd0);
    chk("rst_result1", r1_result, 32'd0);
    chk("rst_zero0", 32'(r0_zero), 32'd0);
    chk("rst_zero1", 32'(r1_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, OP_ADD, 32'(i), 32'd1, 1'b1, 1'b1, OP_SUB, 32'(i), 32'd1, 1'b1, g);
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      chk("contend_gnt", 32'(g), 32'(exp_g));
    end
    idle(1'b1, 1'b1);

    run_op("add_5_7", OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, OP_SUB, 32'd9, 32'd9, 1'b1, g);
    chk("sub_9_9_gnt", 32'(g), 32'd1);
    idle(1'b1, 1'b1);
    chk("sub_9_9_result", r1_result, 32'd0);
    chk("sub_9_9_zero", 32'(r1_zero), 32'd1);

    run_op("sll_1_31", OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
    run_op("srl_b32", OP_SRL, 32'hFFFF_FFFF, 32'd32, 32'd0, 1'b1);
    run_op("slt_ffff_1", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

    cycle(1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, g);
    chk("bp_fill_gnt", 32'(g), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 1'b1, OP_ADD, 32'(i), 32'(i), 1'b1, g);
      chk("bp_r1_gnt", 32'(g), 32'd1);
    end
    cycle(1'b1, OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1, 1'b1, OP_ADD, 32'd3, 32'd3, 1'b1, g);
    chk("bp_refill_gnt", 32'(g), 32'd0);
    idle(1'b1, 1'b1);
    chk("bp_refill_valid", 32'(r0_rsp_valid), 32'd1);
    chk("bp_refill_result", r0_result, 32'hF00F_F00F);
    idle(1'b1, 1'b1);

    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p]) begin
          pv[p]  = ($urandom_range(0, 3) != 0);
          pop[p] = 3'($urandom_range(0, 7));
          pa[p]  = pick();
          pb[p]  = pick();
        end
        rr[p] = ($urandom_range(0, 2) != 0);
      end
      cycle(pv[0], pop[0], pa[0], pb[0], rr[0], pv[1], pop[1], pa[1], pb[1], rr[1], g);
      if (g == 0) pv[0] = 1'b0;
      if (g == 1) pv[1] = 1'b0;
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, OP_ADD, 32'd3, 32'd4, 1'b0, g);
    chk("mid_r1_gnt", 32'(g), 32'd1);
    cycle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, g);
    chk("mid_r0_gnt", 32'(g), 32'd0);
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0; r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    chk("mid_pre_rsp_valid1", 32'(r1_rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid1", 32'(r1_rsp_valid), 32'd0);
    chk("mid_rst_result1", r1_result, 32'd0);
    chk("mid_rst_rsp_valid0", 32'(r0_rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, OP_ADD, 32'd2, 32'd2, 1'b1, 1'b1, OP_ADD, 32'd6, 32'd6, 1'b1, g);
    chk("post_rst_gnt", 32'(g), 32'd0);

    repeat (3) idle(1'b1, 1'b1);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
